// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary arbiter slice.
// Holds the FSM state encoding and a decimal range helper.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int DIGIT_W   = 4;
    localparam int DEC_BASE  = 10;
    localparam int MAX_DIGIT = 9;

    function automatic int max_val(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * DEC_BASE;
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Request/response bundle between requesters and the shared converter.
// master = requester side, slave = converter side.
interface bcd2bin_if
    import bcd2bin_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
);

    logic [NREQ-1:0]                req_valid;
    logic [NREQ*DIGIT_W*DIGITS-1:0] req_bcd;
    logic [NREQ-1:0]                req_ready;
    logic [NREQ-1:0]                rsp_valid;
    logic [OUT_W-1:0]               rsp_bin;
    logic                           rsp_err;
    logic                           busy;

    modport master (
        output req_valid, req_bcd,
        input  req_ready, rsp_valid, rsp_bin, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_bcd,
        output req_ready, rsp_valid, rsp_bin, rsp_err, busy
    );

endinterface

// File: rtl/bcd2bin_arbiter_rr.sv
// Round-robin one-hot grant; ptr holds the last served id so that
// ptr+1 has the highest priority. Reset favours requester 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            upd,
    input  logic [IDW-1:0]  upd_id,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    localparam int PW = $clog2(2 * NREQ);

    logic [IDW-1:0]    ptr;
    logic [2*NREQ-1:0] dbl;
    logic [PW-1:0]     pos;
    logic              found;

    always_ff @(posedge clk) begin
        if (rst) ptr <= IDW'(NREQ - 1);
        else if (upd) ptr <= upd_id;
    end

    // Doubled request vector turns the circular scan into a linear one.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        pos    = '0;
        dbl    = {req, req};
        for (int k = 1; k <= NREQ; k++) begin
            pos = PW'(ptr) + PW'(k);
            if (!found && dbl[pos]) begin
                found       = 1'b1;
                gnt_id      = (pos >= PW'(NREQ)) ? IDW'(pos - PW'(NREQ)) : IDW'(pos);
                gnt[gnt_id] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Shared iterative BCD-to-binary converter, one digit per cycle, MSD first.
// BCD2BIN_CLAMP_EN: clamp bad nibbles to 9 instead of forcing rsp_bin to 0.
module bcd2bin_arbiter
    import bcd2bin_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input logic       clk,
    input logic       rst,
    bcd2bin_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WW  = DIGIT_W * DIGITS;

    state_t               state, state_nx;
    logic [NREQ-1:0]      gnt;
    logic [IDW-1:0]       gnt_id, id;
    logic [WW-1:0]        word;
    logic [CW-1:0]        cnt;
    logic [OUT_W-1:0]     acc, acc_nx, bin_q;
    logic                 err, err_nx, err_q;
    logic [DIGIT_W-1:0]   nib, dig;
    logic                 bad, accept, last;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .upd    (state == DONE),
        .upd_id (id),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign accept = (state == IDLE) && !rst && (|gnt);
    assign last   = (cnt == '0);
    assign nib    = word[cnt*DIGIT_W +: DIGIT_W];
    assign bad    = nib > DIGIT_W'(MAX_DIGIT);
`ifdef BCD2BIN_CLAMP_EN
    assign dig    = bad ? DIGIT_W'(MAX_DIGIT) : nib;
`else
    assign dig    = nib;
`endif
    assign acc_nx = (acc << 3) + (acc << 1) + OUT_W'(dig);
    assign err_nx = err | bad;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst) bus.req_ready = gnt;
                bus.busy = accept;
                if (accept) state_nx = CONV;
            end
            CONV: begin
                bus.busy = !rst;
                if (last) state_nx = DONE;
            end
            DONE: begin
                bus.busy = !rst;
                if (!rst) bus.rsp_valid[id] = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            id    <= '0;
            cnt   <= '0;
            acc   <= '0;
            err   <= 1'b0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            word <= bus.req_bcd[gnt_id*WW +: WW];
            id   <= gnt_id;
            cnt  <= CW'(DIGITS - 1);
            acc  <= '0;
            err  <= 1'b0;
        end else if (state == CONV) begin
            acc <= acc_nx;
            err <= err_nx;
            cnt <= cnt - CW'(1);
            if (last) begin
`ifdef BCD2BIN_CLAMP_EN
                bin_q <= acc_nx;
`else
                bin_q <= err_nx ? '0 : acc_nx;
`endif
                err_q <= err_nx;
            end
        end
    end

    assign bus.rsp_bin = bin_q;
    assign bus.rsp_err = err_q;

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Randomized and directed bench for bcd2bin_arbiter.
// Cycle-level reference model checks grants, latency and results.
module tb_bcd2bin_arbiter;
    import bcd2bin_pkg::*;

    localparam int NREQ   = 2;
    localparam int DIGITS = 4;
    localparam int OUT_W  = 14;
    localparam int WW     = DIGIT_W * DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd2bin_if #(.NREQ(NREQ), .DIGITS(DIGITS), .OUT_W(OUT_W)) bus ();

    bcd2bin_arbiter #(.NREQ(NREQ), .DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    bit              pend[NREQ];
    logic [WW-1:0]   pword[NREQ];
    logic [WW-1:0]   idle_word[NREQ];
    bit              rnd = 1'b0;
    bit              rst_req = 1'b1;
    logic [NREQ-1:0] xfer = '0;

    int phase = 0;
    int mid = 0;
    int mpri = 0;
    int mexp = 0;
    bit merr = 1'b0;
    int last_bin = 0;
    bit last_err = 1'b0;

    typedef struct {
        int id;
        int bin;
        bit err;
    } rsp_t;
    rsp_t log_q[$];

    function automatic int ref_conv(input logic [WW-1:0] w, output bit e);
        int v;
        int n;
        v = 0;
        e = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            n = int'(w[d*DIGIT_W +: DIGIT_W]);
            if (n > MAX_DIGIT) begin
                e = 1'b1;
                n = MAX_DIGIT;
            end
            v = v * DEC_BASE + n;
        end
`ifndef BCD2BIN_CLAMP_EN
        if (e) v = 0;
`endif
        return v;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        int v;
        if ($urandom_range(4, 0) == 0) return WW'($urandom);
        v = int'($urandom_range(max_val(DIGITS), 0));
        w = '0;
        for (int d = 0; d < DIGITS; d++) begin
            w[d*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % DEC_BASE);
            v = v / DEC_BASE;
        end
        return w;
    endfunction

    function automatic int lg_bin(input int k);
        return (log_q.size() > k) ? log_q[k].bin : -1;
    endfunction

    function automatic int lg_id(input int k);
        return (log_q.size() > k) ? log_q[k].id : -1;
    endfunction

    function automatic int lg_err(input int k);
        return (log_q.size() > k) ? int'(log_q[k].err) : -1;
    endfunction

    task automatic model();
        logic [NREQ-1:0] eg;
        int w;
        int i;
        bit e;
        if (rst) begin
            check("rst_ready", bus.req_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            phase    = 0;
            mpri     = 0;
            last_bin = 0;
            last_err = 1'b0;
            return;
        end
        if (phase == 0) begin
            eg = '0;
            w  = 0;
            for (int k = 0; k < NREQ; k++) begin
                i = (mpri + k) % NREQ;
                if (bus.req_valid[i] && eg == '0) begin
                    eg[i] = 1'b1;
                    w     = i;
                end
            end
            check("idle_ready", bus.req_ready, eg);
            check("idle_busy", bus.busy, eg != '0);
            check("idle_rsp_valid", bus.rsp_valid, 0);
            check("hold_bin", bus.rsp_bin, last_bin);
            check("hold_err", bus.rsp_err, last_err);
            if (eg != '0) begin
                mid   = w;
                mexp  = ref_conv(bus.req_bcd[w*WW +: WW], e);
                merr  = e;
                phase = 1;
            end
        end else begin
            check("conv_ready", bus.req_ready, 0);
            check("conv_busy", bus.busy, 1);
            if (phase == DIGITS + 1) begin
                check("rsp_valid", bus.rsp_valid, 1 << mid);
                check("rsp_bin", bus.rsp_bin, mexp);
                check("rsp_err", bus.rsp_err, merr);
                log_q.push_back('{id: mid, bin: mexp, err: merr});
                last_bin = mexp;
                last_err = merr;
                mpri     = (mid + 1) % NREQ;
                phase    = 0;
            end else begin
                check("conv_rsp_valid", bus.rsp_valid, 0);
                check("conv_hold_bin", bus.rsp_bin, last_bin);
                phase++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (xfer[i]) pend[i] = 1'b0;
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        pend[i]  = 1'b1;
                        pword[i] = rand_word();
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rst = ($urandom_range(199, 0) == 0);
        end else begin
            rst = rst_req;
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_bcd[i*WW +: WW] = pend[i] ? pword[i] : (rnd ? WW'($urandom) : idle_word[i]);
        end
        #1;
        model();
        xfer = bus.req_valid & bus.req_ready;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i]      = 1'b0;
            pword[i]     = '0;
            idle_word[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_bcd   = '0;

        rst_req = 1'b1;
        run(3);
        rst_req = 1'b0;
        run(1);
        check("reset_bin", bus.rsp_bin, 0);
        check("reset_busy", bus.busy, 0);

        log_q.delete();
        pend[0] = 1'b1; pword[0] = 16'h1234;
        run(8);
        check("d1234_n", log_q.size(), 1);
        check("d1234_bin", lg_bin(0), 1234);
        check("d1234_id", lg_id(0), 0);
        check("d1234_err", lg_err(0), 0);

        log_q.delete();
        pend[0] = 1'b1; pword[0] = 16'h9999;
        run(8);
        pend[1] = 1'b1; pword[1] = 16'h0000;
        run(8);
        check("d9999_bin", lg_bin(0), 9999);
        check("d0000_bin", lg_bin(1), 0);
        check("d0000_id", lg_id(1), 1);

        log_q.delete();
        pend[0] = 1'b1; pword[0] = 16'h0042;
        pend[1] = 1'b1; pword[1] = 16'h0777;
        run(14);
        check("both_first_id", lg_id(0), 0);
        check("both_first_bin", lg_bin(0), 42);
        check("both_second_id", lg_id(1), 1);
        check("both_second_bin", lg_bin(1), 777);

        log_q.delete();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    pend[i]  = 1'b1;
                    pword[i] = 16'h0100 + 16'(r);
                end
            end
            run(6);
        end
        for (int k = 0; k < 4; k++) check("alt_id", lg_id(k), k % 2);
        run(8);

        log_q.delete();
        pend[1] = 1'b1; pword[1] = 16'h12A4;
        run(8);
`ifdef BCD2BIN_CLAMP_EN
        check("bad_bin", lg_bin(0), 1294);
`else
        check("bad_bin", lg_bin(0), 0);
`endif
        check("bad_err", lg_err(0), 1);

        log_q.delete();
        pend[0] = 1'b1; pword[0] = 16'h5555;
        run(2);
        rst_req = 1'b1;
        run(1);
        rst_req = 1'b0;
        run(10);
        check("rst_mid_n", log_q.size(), 0);
        pend[0] = 1'b1; pword[0] = 16'h0011;
        pend[1] = 1'b1; pword[1] = 16'h0022;
        run(12);
        check("post_rst_id0", lg_id(0), 0);
        check("post_rst_id1", lg_id(1), 1);

        log_q.delete();
        idle_word[0] = 16'h2222;
        pend[0] = 1'b1; pword[0] = 16'h1111;
        run(8);
        check("sample_bin", lg_bin(0), 1111);
        idle_word[0] = '0;

        log_q.delete();
        rnd = 1'b1;
        run(3000);
        rnd = 1'b0;
        check("rnd_some_rsp", log_q.size() > 50, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd2bin_arbiter.md
Name: bcd2bin_arbiter

Overview:
Shares one iterative BCD-to-binary conversion datapath between NREQ requesters, for example the keypad price-entry path and the coin-total path.
- Round-robin arbitration picks one requester at a time.
- The winner's 4-digit packed BCD word is latched and converted most-significant digit first, one digit per cycle (acc = acc*10 + digit).
- The binary result is returned with a one-hot response strobe.
- Sits between the vending-machine front-end registers and the price/credit comparison logic.

Parameters:
NREQ, 2, number of requesters (2..4)
DIGITS, 4, BCD digits per request word
OUT_W, 14, result width; must hold 10^DIGITS-1 (9999 needs 14 bits)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request
req_bcd  input  NREQ*4*DIGITS  packed BCD words; requester i occupies bits [i*16 +: 16]; digit 0 is the LSD in the low nibble
req_ready  output  NREQ  one-hot grant/accept; a transfer occurs when valid & ready are both high
rsp_valid  output  NREQ  one-hot, single-cycle result strobe to the owning requester
rsp_bin  output  OUT_W  binary result; valid while any rsp_valid bit is high
rsp_err  output  1  a non-decimal nibble was present; valid with rsp_valid
busy  output  1  high from the accept cycle through the response cycle

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: req_ready=0, rsp_valid=0, rsp_bin=0, rsp_err=0, busy=0, state=IDLE, round-robin pointer set so requester 0 has highest priority.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - req_ready is driven combinationally, one-hot, to the round-robin winner among the asserted req_valid bits.
  - At the accept edge: latch the winner's BCD word and id, clear acc and the err flag, set digit counter = DIGITS-1, go to CONV.
  - No request: stay in IDLE with req_ready=0.
- CONV:
  - Each cycle: acc <= acc*10 + clamp(digit[cnt]); decrement cnt; if digit > 9, set err.
  - After DIGITS cycles, go to DONE.
- DONE:
  - rsp_valid[id]=1 for exactly one cycle, with rsp_bin and rsp_err.
  - The round-robin pointer updates to id, so id+1 has the highest priority next.
  - Return to IDLE.
- Latency: accept at cycle T → rsp_valid at T+DIGITS+1 (T+5 by default). The next accept is possible at T+DIGITS+2. req_ready is never high outside IDLE.
- Arithmetic: acc is OUT_W bits; *10 is computed as (acc<<3)+(acc<<1). No overflow is possible for valid input.
- Invalid digit, without the optional feature: rsp_bin=0, rsp_err=1.
- Requester behaviour: a requester may drop req_valid before it is granted, and no transfer occurs. req_bcd is sampled only at the accept edge; later changes are ignored.
- Simultaneous requests: exactly one grant per accept. The losing requester holds its request and is granted next.
- Reset mid-operation: the in-flight request is dropped and no rsp_valid is produced. All state returns to reset values on the next edge.
- rsp_bin and rsp_err are held at their last values between responses. Consumers sample them only on rsp_valid.

Optional Feature:
BCD2BIN_CLAMP_EN
- Defined: any nibble > 9 is treated as 9 in the accumulation; rsp_bin carries the clamped value and rsp_err is still 1.
- Undefined: an invalid input forces rsp_bin=0 with rsp_err=1; the clamp logic is not synthesised.

Decomposition:
- Package bcd2bin_pkg holds:
  - state enum {IDLE, CONV, DONE}
  - DIGIT_W=4, DEC_BASE=10, MAX_DIGIT=9
  - function max_val(DIGITS) returning 10^DIGITS-1
- One sub-module, rr_arbiter (NREQ): a combinational one-hot grant from the request vector and the pointer, with a registered pointer updated on an update strobe. The FSM and accumulator stay in the top module.

Test Plan:
- After reset, req0 only with 0x1234 → req_ready=2'b01 at T; rsp_valid=2'b01, rsp_bin=1234, rsp_err=0 at T+5; busy high T..T+5.
- req0 with 0x9999 → rsp_bin=9999. req1 with 0x0000 → rsp_bin=0. Confirms full range and zero.
- req0=0x0042 and req1=0x0777 asserted together, held → req0 served first (rsp 42 at T+5); req1 accepted at T+6, rsp 777 at T+11. Repeat with both held: grants alternate 0,1,0,1.
- req1 with 0x12A4 → without macro: rsp_bin=0, rsp_err=1. With BCD2BIN_CLAMP_EN: rsp_bin=1294, rsp_err=1.
- Accept 0x5555, assert rst at T+2 for one cycle → no rsp_valid at any later cycle; after release, req1 and req0 together → req0 granted first.
- Change req_bcd from 0x1111 to 0x2222 at T+1 after acceptance → rsp_bin=1111.
